// File: rtl/subfilter_host.sv
// Handshake host for one polyphase subfilter stage: an input FIFO feeding the
// subfilter's req_in/ack_in port and an output register draining req_out/ack_out.
module subfilter_host #(
    parameter int unsigned DWIDTH     = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned AWIDTH     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_data,
    input  logic              sub_req_in,
    output logic              sub_ack_in,
    output logic [DWIDTH-1:0] sub_data_in,
    input  logic              sub_req_out,
    output logic              sub_ack_out,
    input  logic [DWIDTH-1:0] sub_data_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic [AWIDTH:0]   fifo_count
);
    typedef enum logic {StIdle, StAck} state_e;

    localparam logic [AWIDTH:0] Depth = (AWIDTH + 1)'(FIFO_DEPTH);

    state_e            in_state_q, in_state_d;
    state_e            out_state_q, out_state_d;
    logic [DWIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [AWIDTH:0]   count_q, count_d;
    logic              in_ready_q, in_ready_d;
    logic [DWIDTH-1:0] sub_data_in_q, sub_data_in_d;
    logic              out_valid_q, out_valid_d;
    logic [DWIDTH-1:0] out_data_q, out_data_d;
    logic              push, pop, capture;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_state_q  <= StIdle;
            out_state_q <= StIdle;
        end else begin
            in_state_q  <= in_state_d;
            out_state_q <= out_state_d;
        end
    end

    // Each ack lasts one cycle: ACK always returns to IDLE, and IDLE blocks a re-pop.
    always_comb begin
        pop         = (in_state_q == StIdle) && sub_req_in && (count_q != '0);
        capture     = (out_state_q == StIdle) && sub_req_out && (!out_valid_q || out_ready);
        in_state_d  = pop ? StAck : StIdle;
        out_state_d = capture ? StAck : StIdle;
    end

    always_comb begin
        push     = in_valid && in_ready_q;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        // No bypass: readiness follows the registered occupancy only.
        in_ready_d    = count_d < Depth;
        sub_data_in_d = pop ? mem_q[rd_ptr_q] : sub_data_in_q;
        out_data_d    = capture ? sub_data_out : out_data_q;
        out_valid_d   = out_valid_q;
        if (capture) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            in_ready_q    <= 1'b0;
            sub_data_in_q <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            in_ready_q    <= in_ready_d;
            sub_data_in_q <= sub_data_in_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign in_ready    = in_ready_q;
    assign sub_ack_in  = (in_state_q == StAck);
    assign sub_data_in = sub_data_in_q;
    assign sub_ack_out = (out_state_q == StAck);
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign fifo_count  = count_q;

endmodule

// File: tb/tb_subfilter_host.sv
// Self-checking bench for subfilter_host: table-driven fill, scoreboarded drain/wrap,
// output backpressure, and a closed loop against a 4-tap FIR subfilter model.
module tb_subfilter_host;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [15:0] in_data = '0;
    logic        sub_req_in = 1'b0, sub_ack_in;
    logic [15:0] sub_data_in;
    logic        sub_req_out = 1'b0, sub_ack_out;
    logic [15:0] sub_data_out = '0;
    logic        out_valid, out_ready = 1'b0;
    logic [15:0] out_data;
    logic [2:0]  fifo_count;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_out = 0;
    logic [15:0] exp_q[$];
    logic [15:0] fifo_exp[$];
    logic [15:0] hist[4];

    subfilter_host #(.DWIDTH(16), .FIFO_DEPTH(4), .AWIDTH(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .sub_req_in(sub_req_in), .sub_ack_in(sub_ack_in), .sub_data_in(sub_data_in),
        .sub_req_out(sub_req_out), .sub_ack_out(sub_ack_out), .sub_data_out(sub_data_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Downstream consumer: a handshake completes at the coming edge.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL out_extra: got %0h, expected no output", out_data);
            end else begin
                chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
        end
    end

    // Subfilter input side: request, hold req across the ack edge, then release.
    task automatic fetch_in(output logic [15:0] d);
        bit ok = 1'b0;
        sub_req_in = 1'b1;
        for (int n = 0; n < 20 && !ok; n++) begin
            step();
            if (sub_ack_in) ok = 1'b1;
        end
        chk("ack_in_seen", 32'(ok), 32'd1);
        d = sub_data_in;
        step();
        chk("ack_in_one_cycle", 32'(sub_ack_in), 32'd0);
        sub_req_in = 1'b0;
    endtask

    task automatic give_out(input logic [15:0] y);
        bit ok = 1'b0;
        sub_data_out = y;
        sub_req_out  = 1'b1;
        for (int n = 0; n < 20 && !ok; n++) begin
            step();
            if (sub_ack_out) ok = 1'b1;
        end
        chk("ack_out_seen", 32'(ok), 32'd1);
        sub_req_out = 1'b0;
        step();
        chk("ack_out_one_cycle", 32'(sub_ack_out), 32'd0);
    endtask

    // One closed-loop transaction: upstream sample -> FIR model -> downstream result.
    task automatic loop_txn(input logic [15:0] x, input logic [15:0] golden);
        logic [15:0] got;
        logic signed [31:0] acc;
        in_valid = 1'b1;
        in_data  = x;
        step();
        in_valid = 1'b0;
        exp_q.push_back(golden);
        fetch_in(got);
        chk("loop_x", 32'(got), 32'(x));
        for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = got;
        acc = 0;
        for (int i = 0; i < 4; i++) acc += $signed(hist[i]) * 32'sh4000;
        give_out(16'(acc >>> 15));
    endtask

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic [2:0]  cnt;
        logic        rdy;
    } fill_t;

    initial begin
        fill_t       fill_tab[5];
        logic [15:0] d;
        logic [15:0] golden[6];
        int          cnt_m, sent, got;
        bit          pushed, prev_ack, acc;

        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fill_t       fill_tab[5];
        logic [15:0] d;
        logic [15:0] golden[6];
        int          cnt_m, sent, got;
        bit          pushed, prev_ack, acc;

        fill_tab[0] = '{1'b1, 16'h0001, 3'd1, 1'b1};
        fill_tab[1] = '{1'b1, 16'h0002, 3'd2, 1'b1};
        fill_tab[2] = '{1'b1, 16'h0003, 3'd3, 1'b1};
        fill_tab[3] = '{1'b1, 16'h0004, 3'd4, 1'b0};
        fill_tab[4] = '{1'b1, 16'h0005, 3'd4, 1'b0};
        golden      = '{16'h0800, 16'h1000, 16'h1800, 16'h2000, 16'h2000, 16'h2000};
        for (int i = 0; i < 4; i++) hist[i] = '0;

        // Reset with random stimulus: every output held at zero.
        for (int i = 0; i < 6; i++) begin
            in_valid     = 1'($urandom);
            in_data      = 16'($urandom);
            sub_req_in   = 1'($urandom);
            sub_req_out  = 1'($urandom);
            sub_data_out = 16'($urandom);
            out_ready    = 1'($urandom);
            step();
            chk("reset_outputs",
                32'({in_ready, sub_ack_in, sub_data_in, sub_ack_out, out_valid, fifo_count}),
                32'd0);
            chk("reset_out_data", 32'(out_data), 32'd0);
        end
        in_valid = 1'b0; sub_req_in = 1'b0; sub_req_out = 1'b0; out_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("release_ready_low", 32'(in_ready), 32'd0);
        step();
        chk("release_ready_high", 32'(in_ready), 32'd1);

        // Fill: fifth push must be refused.
        for (int i = 0; i < 5; i++) begin
            acc = (i == 0) ? 1'b1 : fill_tab[i-1].rdy;
            in_valid = fill_tab[i].v;
            in_data  = fill_tab[i].d;
            if (acc) fifo_exp.push_back(fill_tab[i].d);
            step();
            chk("fill_count", 32'(fifo_count), 32'(fill_tab[i].cnt));
            chk("fill_ready", 32'(in_ready), 32'(fill_tab[i].rdy));
        end
        in_valid = 1'b0;

        // Drain in order.
        for (int i = 0; i < 4; i++) begin
            fetch_in(d);
            chk("drain_data", 32'(d), 32'(fifo_exp.pop_front()));
        end
        chk("drain_count", 32'(fifo_count), 32'd0);

        // Request on empty FIFO: no ack until a sample lands, then ack one edge later.
        sub_req_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("empty_no_ack", 32'(sub_ack_in), 32'd0);
        end
        in_valid = 1'b1;
        in_data  = 16'h0005;
        step();
        in_valid = 1'b0;
        chk("push_edge_no_ack", 32'(sub_ack_in), 32'd0);
        chk("push_edge_count", 32'(fifo_count), 32'd1);
        step();
        chk("late_ack", 32'(sub_ack_in), 32'd1);
        chk("late_data", 32'(sub_data_in), 32'h0005);
        step();
        sub_req_in = 1'b0;
        chk("late_ack_drop", 32'(sub_ack_in), 32'd0);
        chk("late_count", 32'(fifo_count), 32'd0);
        chk("late_data_hold", 32'(sub_data_in), 32'h0005);

        // Wrap: continuous stream of -8..3, subfilter requests every third cycle.
        cnt_m = 0; sent = 0; got = 0; prev_ack = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'hFFF8;
        for (int cyc = 0; cyc < 200 && got < 12; cyc++) begin
            sub_req_in = (cyc % 3 == 0);
            pushed = in_valid && in_ready;
            if (pushed) fifo_exp.push_back(in_data);
            step();
            if (pushed) begin
                sent++;
                if (sent < 12) in_data = 16'(sent - 8);
                else in_valid = 1'b0;
            end
            if (sub_ack_in) begin
                chk("wrap_ack_gap", 32'(prev_ack), 32'd0);
                if (fifo_exp.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL wrap_extra_pop: got %0h, expected no ack", sub_data_in);
                end else begin
                    chk("wrap_data", 32'(sub_data_in), 32'(fifo_exp.pop_front()));
                end
                got++;
            end
            cnt_m = cnt_m + int'(pushed) - int'(sub_ack_in);
            chk("wrap_count", 32'(fifo_count), 32'(cnt_m));
            prev_ack = sub_ack_in;
        end
        sub_req_in = 1'b0;
        in_valid   = 1'b0;
        chk("wrap_all_out", 32'(got), 32'd12);

        // Output backpressure.
        out_ready    = 1'b0;
        sub_data_out = 16'h7FFF;
        sub_req_out  = 1'b1;
        exp_q.push_back(16'h7FFF);
        step();
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_data", 32'(out_data), 32'h7FFF);
        chk("bp_ack", 32'(sub_ack_out), 32'd1);
        sub_req_out = 1'b0;
        step();
        chk("bp_ack_drop", 32'(sub_ack_out), 32'd0);
        sub_data_out = 16'h8000;
        sub_req_out  = 1'b1;
        exp_q.push_back(16'h8000);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_stall_ack", 32'(sub_ack_out), 32'd0);
            chk("bp_stall_data", 32'(out_data), 32'h7FFF);
        end
        out_ready = 1'b1;
        step();
        chk("bp_release_ack", 32'(sub_ack_out), 32'd1);
        chk("bp_release_valid", 32'(out_valid), 32'd1);
        chk("bp_release_data", 32'(out_data), 32'h8000);
        sub_req_out = 1'b0;
        step();
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Closed loop against the FIR model.
        for (int i = 0; i < 6; i++) loop_txn(16'h1000, golden[i]);

        // Reset in the middle of both acks.
        in_valid = 1'b1;
        in_data  = 16'h7777;
        step();
        step();
        in_valid     = 1'b0;
        sub_req_in   = 1'b1;
        sub_req_out  = 1'b1;
        sub_data_out = 16'h1234;
        step();
        chk("mid_ack_in", 32'(sub_ack_in), 32'd1);
        chk("mid_ack_out", 32'(sub_ack_out), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_ack_in", 32'(sub_ack_in), 32'd0);
        chk("rst_ack_out", 32'(sub_ack_out), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        sub_req_in  = 1'b0;
        sub_req_out = 1'b0;
        for (int i = 0; i < 4; i++) hist[i] = '0;
        step();
        rst = 1'b1;
        step();
        for (int i = 0; i < 3; i++) loop_txn(16'h1000, golden[i]);
        repeat (4) step();
        chk("no_pending", 32'(exp_q.size()), 32'd0);
        chk("total_outputs", 32'(n_out), 32'd11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
